// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory bus transaction per load/store, with
// byte/half/word lanes, sign/zero extension, misalignment and timeout traps.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } lsu_req_t;

    state_t   state, state_nxt;
    lsu_req_t req_q, req_new;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          mem_req_q;
    logic          err_mis_q;
    logic          illegal, misalign, bad, timeout;

    // Alignment / encoding checks on the incoming instruction
    always_comb begin
        illegal  = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (funct3_i[2] && we_i);
        misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
        bad      = illegal || misalign;
        timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Build the bus-side request: aligned address, byte enables, replicated store data
    always_comb begin
        req_new        = '0;
        req_new.we     = we_i;
        req_new.funct3 = funct3_i;
        req_new.lane   = addr_i[1:0];
        req_new.addr   = {addr_i[31:2], 2'b00};
        case (funct3_i[1:0])
            2'b00: begin
                req_new.be    = 4'b0001 << addr_i[1:0];
                req_new.wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                req_new.be    = 4'b0011 << {addr_i[1], 1'b0};
                req_new.wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                req_new.be    = 4'b1111;
                req_new.wdata = wdata_i;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid_i) state_nxt = bad ? ERR : REQ;
            REQ: begin
                if (mem_ack_i)    state_nxt = DONE;
                else if (timeout) state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered bus request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req_q <= (state_nxt == REQ);
        end
    end

    // Request latch, timeout counter, load result and error kind
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q     <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            err_mis_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    req_q     <= req_new;
                    cnt       <= '0;
                    err_mis_q <= bad;
                    if (bad) rdata_q <= '0;
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (mem_ack_i) begin
                        if (!req_q.we) rdata_q <= load_ext(mem_rdata_i, req_q.funct3, req_q.lane);
                    end else if (timeout) begin
                        rdata_q   <= '0;
                        err_mis_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Core- and bus-facing outputs; bus fields are only driven while requesting
    always_comb begin
        case (state)
            IDLE:    stall_o = req_valid_i && !rst_i;
            REQ:     stall_o = !rst_i;
            default: stall_o = 1'b0;
        endcase
        rdata_o       = rdata_q;
        rdata_valid_o = (state == DONE) && !req_q.we;
        misalign_o    = (state == ERR) && err_mis_q;
        bus_err_o     = (state == ERR) && !err_mis_q;
        mem_req_o     = mem_req_q;
        mem_we_o      = mem_req_q && req_q.we;
        mem_addr_o    = mem_req_q ? req_q.addr  : 32'h0;
        mem_be_o      = mem_req_q ? req_q.be    : 4'h0;
        mem_wdata_o   = mem_req_q ? req_q.wdata : 32'h0;
    end
endmodule
